// File: rtl/i2s_rx_frame_ctrl.sv
// I2S receive frame controller: aligns to a left word, pairs left/right words into
// stereo frames and buffers them in a first-word-fall-through FIFO for the consumer.
module i2s_rx_frame_ctrl #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [WORD_WIDTH-1:0]         rx_data_i,
    input  logic                          rx_lr_i,
    input  logic                          rx_write_i,
    output logic [WORD_WIDTH-1:0]         frame_l_o,
    output logic [WORD_WIDTH-1:0]         frame_r_o,
    output logic                          frame_valid_o,
    input  logic                          frame_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          locked_o,
    output logic                          ovf_o,
    output logic                          slip_o,
    input  logic                          err_clr_i
);

    localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W      = ADDR_WIDTH + 1;
    localparam int unsigned FRAME_W    = 2 * WORD_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_L = 2'd1,
        WAIT_R = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WORD_WIDTH-1:0] l_hold_q, l_hold_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  valid_q, valid_d;
    logic                  locked_q, locked_d;
    logic                  ovf_q, ovf_d;
    logic                  slip_q, slip_d;
    logic [FRAME_W-1:0]    mem_q [FIFO_DEPTH];

    logic word_l, word_r;
    logic hold_we, frame_push, slip_set, lock_clr;
    logic pop, full, do_push, drop;

    assign word_l = rx_write_i & ~rx_lr_i;
    assign word_r = rx_write_i &  rx_lr_i;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = WAIT_L;
                WAIT_L:  if (word_l) state_d = WAIT_R;
                WAIT_R:  if (word_r) state_d = WAIT_L;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM control decode
    always_comb begin
        hold_we    = 1'b0;
        frame_push = 1'b0;
        slip_set   = 1'b0;
        lock_clr   = ~en_i | (state_q == IDLE);
        if (en_i) begin
            case (state_q)
                WAIT_L: hold_we = word_l;
                WAIT_R: begin
                    hold_we    = word_l;
                    slip_set   = word_l;
                    frame_push = word_r;
                end
                default: ;
            endcase
        end
    end

    // FIFO bookkeeping and sticky flags; a push into a full FIFO only lands if a pop frees a slot
    always_comb begin
        pop      = valid_q & frame_ready_i;
        full     = (level_q == LVL_W'(FIFO_DEPTH));
        do_push  = frame_push & (~full | pop);
        drop     = frame_push & full & ~pop;

        l_hold_d = hold_we ? rx_data_i : l_hold_q;
        wr_ptr_d = do_push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

        level_d = level_q;
        case ({do_push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        valid_d  = (level_d != '0);

        locked_d = lock_clr ? 1'b0 : (locked_q | frame_push);
        ovf_d    = err_clr_i ? 1'b0 : (ovf_q | drop);
        slip_d   = err_clr_i ? 1'b0 : (slip_q | slip_set);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            l_hold_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
            slip_q   <= 1'b0;
        end else begin
            l_hold_q <= l_hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
            slip_q   <= slip_d;
        end
    end

    // Frame storage carries no reset; contents are don't-care while empty
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {l_hold_q, rx_data_i};
        end
    end

    assign frame_l_o     = mem_q[rd_ptr_q][FRAME_W-1:WORD_WIDTH];
    assign frame_r_o     = mem_q[rd_ptr_q][WORD_WIDTH-1:0];
    assign frame_valid_o = valid_q;
    assign level_o       = level_q;
    assign locked_o      = locked_q;
    assign ovf_o         = ovf_q;
    assign slip_o        = slip_q;

endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// Self-checking bench for i2s_rx_frame_ctrl: expected frames are queued as stimulus
// is driven and compared in order as the consumer drains the FIFO.
module tb_i2s_rx_frame_ctrl;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [W-1:0]  rx_data = '0;
    logic          rx_lr = 1'b0;
    logic          rx_write = 1'b0;
    logic [W-1:0]  frame_l, frame_r;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic [2:0]    level;
    logic          locked, ovf, slip;
    logic          err_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q [$];

    i2s_rx_frame_ctrl #(.WORD_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .rx_data_i(rx_data), .rx_lr_i(rx_lr), .rx_write_i(rx_write),
        .frame_l_o(frame_l), .frame_r_o(frame_r), .frame_valid_o(frame_valid),
        .frame_ready_i(frame_ready), .level_o(level), .locked_o(locked),
        .ovf_o(ovf), .slip_o(slip), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle word strobe; returns 1 ns after the sampling edge
    task automatic send_word(input logic lr, input logic [W-1:0] d);
        rx_lr = lr;
        rx_data = d;
        rx_write = 1'b1;
        tick();
        rx_write = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit expect_stored);
        send_word(1'b0, l);
        send_word(1'b1, r);
        if (expect_stored) exp_q.push_back({l, r});
    endtask

    task automatic check_level(input string name, input logic [2:0] exp);
        checks++;
        if (level !== exp) begin
            failures++;
            $display("FAIL %s: level_o=%0d expected %0d", name, level, exp);
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 50;
        frame_ready = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            if (frame_valid === 1'b1) begin
                checks++;
                if ({frame_l, frame_r} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL %s head: got %h_%h expected %h", name, frame_l, frame_r, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            tick();
            budget--;
        end
        frame_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s timeout: %0d frames never appeared", name, exp_q.size());
            exp_q.delete();
        end
        check_level({name, " empty"}, 3'd0);
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s valid after drain: got %b expected 0", name, frame_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        tick();
        check_level("reset level", 3'd0);
        checks++;
        if ({frame_valid, locked, ovf, slip} !== 4'b0000) begin
            failures++;
            $display("FAIL reset flags: valid/locked/ovf/slip=%b expected 0000", {frame_valid, locked, ovf, slip});
        end
    endtask

    task automatic test_basic();
        en = 1'b1;
        tick();
        send_word(1'b1, 16'h1111);
        send_word(1'b0, 16'hAAAA);
        send_word(1'b1, 16'h5555);
        exp_q.push_back({16'hAAAA, 16'h5555});
        checks++;
        if (frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic valid: got %b expected 1", frame_valid);
        end
        check_level("basic level", 3'd1);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL basic locked: got %b expected 1", locked);
        end
        drain("basic");
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            send_frame(W'(16'h1000 + i), W'(16'h2000 + i), i <= DEPTH);
        end
        check_level("ovf level", 3'd4);
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf flag: got %b expected 1", ovf);
        end
        drain("ovf");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf clear: got %b expected 0", ovf);
        end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 4; i++) begin
            send_frame(W'(16'h3000 + i), W'(16'h4000 + i), 1'b1);
        end
        send_word(1'b0, 16'h3AAA);
        rx_lr = 1'b1;
        rx_data = 16'h4BBB;
        rx_write = 1'b1;
        frame_ready = 1'b1;
        checks++;
        if ({frame_l, frame_r} !== exp_q[0]) begin
            failures++;
            $display("FAIL pushpop head: got %h_%h expected %h", frame_l, frame_r, exp_q[0]);
        end
        tick();
        rx_write = 1'b0;
        frame_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({16'h3AAA, 16'h4BBB});
        check_level("pushpop level", 3'd4);
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL pushpop ovf: got %b expected 0", ovf);
        end
        drain("pushpop");
    endtask

    task automatic test_slip();
        send_word(1'b0, 16'h0001);
        send_word(1'b0, 16'h0002);
        checks++;
        if (slip !== 1'b1) begin
            failures++;
            $display("FAIL slip set: got %b expected 1", slip);
        end
        send_word(1'b1, 16'h0003);
        exp_q.push_back({16'h0002, 16'h0003});
        drain("slip");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (slip !== 1'b0) begin
            failures++;
            $display("FAIL slip clear: got %b expected 0", slip);
        end
    endtask

    task automatic test_en_drop();
        send_frame(16'h5001, 16'h6001, 1'b1);
        send_frame(16'h5002, 16'h6002, 1'b1);
        send_word(1'b0, 16'h7777);
        en = 1'b0;
        tick();
        tick();
        check_level("endrop level", 3'd2);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL endrop locked: got %b expected 0", locked);
        end
        drain("endrop");
        en = 1'b1;
        tick();
        send_word(1'b1, 16'h9999);
        send_frame(16'h1234, 16'h5678, 1'b1);
        drain("realign");
    endtask

    task automatic test_reset_mid();
        send_word(1'b0, 16'h0F0F);
        send_word(1'b0, 16'h0E0E);
        send_word(1'b1, 16'h0D0D);
        for (int i = 0; i < 2; i++) begin
            send_frame(W'(16'h8000 + i), W'(16'h9000 + i), 1'b0);
        end
        check_level("mid pre-reset level", 3'd3);
        #2;
        rst = 1'b1;
        #1;
        check_level("mid async level", 3'd0);
        checks++;
        if ({frame_valid, locked, ovf, slip} !== 4'b0000) begin
            failures++;
            $display("FAIL mid async flags: valid/locked/ovf/slip=%b expected 0000", {frame_valid, locked, ovf, slip});
        end
        #10;
        rst = 1'b0;
        tick();
        tick();
        send_frame(16'hC001, 16'hD001, 1'b1);
        drain("post-reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop_full();
        test_slip();
        test_en_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
